// File: rtl/weight_row_packer.sv
// Packs DIN_W-bit DMA words into ROW_W-bit rows and writes them round-robin across weight banks.
// Define WEIGHT_PACKER_PARTIAL_FLUSH_EN to write a zero-padded partial last row on dma_done.
module weight_row_packer #(
   parameter int unsigned DIN_W      = 32,
   parameter int unsigned ROW_W      = 128,
   parameter int unsigned BANK_NUM   = 9,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned BITS_TRANS = 18
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic [BITS_TRANS-1:0] num_words_i,
   input  logic [DIN_W-1:0]      dma_din_i,
   input  logic                  dma_din_vld_i,
   input  logic                  dma_done_i,
   output logic                  wr_en_o,
   output logic [3:0]            wr_bank_o,
   output logic [ADDR_W-1:0]     wr_addr_o,
   output logic [ROW_W-1:0]      wr_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  addr_ovf_o
);

   localparam int unsigned Lanes = ROW_W / DIN_W;
   localparam int unsigned LaneW = $clog2(Lanes);
   localparam logic [LaneW-1:0] LastLane = LaneW'(Lanes - 1);
   localparam logic [3:0] LastBank = 4'(BANK_NUM - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StFill  = 2'd1;
   localparam logic [1:0] StFlush = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

`ifdef WEIGHT_PACKER_PARTIAL_FLUSH_EN
   localparam bit FlushEn = 1'b1;
`else
   localparam bit FlushEn = 1'b0;
`endif

   logic [1:0]            state_q, state_d;
   logic [BITS_TRANS-1:0] num_words_q, num_words_d;
   logic [BITS_TRANS-1:0] word_cnt_q, word_cnt_d;
   logic [ROW_W-1:0]      row_buf_q, row_buf_d;
   logic [ROW_W-1:0]      wr_data_q, wr_data_d;
   logic                  wr_en_q, wr_en_d;
   logic [3:0]            bank_q, bank_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  ovf_q, ovf_d;

   logic [LaneW-1:0]      lane;
   logic                  accept;

   assign lane   = word_cnt_q[LaneW-1:0];
   assign accept = (state_q == StFill) && dma_din_vld_i && (word_cnt_q < num_words_q);

   always_comb begin
      state_d     = state_q;
      num_words_d = num_words_q;
      word_cnt_d  = word_cnt_q;
      row_buf_d   = row_buf_q;
      wr_data_d   = wr_data_q;
      wr_en_d     = 1'b0;
      bank_d      = bank_q;
      addr_d      = addr_q;
      ovf_d       = ovf_q;

      // Target advances once the presented write has been consumed.
      if (wr_en_q) begin
         if (bank_q == LastBank) begin
            bank_d = '0;
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == '1) begin
               ovf_d = 1'b1;
            end
         end else begin
            bank_d = bank_q + 4'd1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               num_words_d = num_words_i;
               word_cnt_d  = '0;
               row_buf_d   = '0;
               bank_d      = '0;
               addr_d      = '0;
               ovf_d       = 1'b0;
               state_d     = (num_words_i == '0) ? StDone : StFill;
            end
         end
         StFill: begin
            if (accept) begin
               word_cnt_d = word_cnt_q + BITS_TRANS'(1);
               for (int k = 0; k < Lanes; k++) begin
                  if (lane == LaneW'(k)) begin
                     row_buf_d[k*DIN_W +: DIN_W] = dma_din_i;
                  end
               end
               if (lane == LastLane) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = row_buf_d;
                  row_buf_d = '0;
               end
            end
            if (wr_en_q && (word_cnt_q == num_words_q)) begin
               state_d = StDone;
            end else if (dma_done_i && ((word_cnt_d[LaneW-1:0] != '0) ||
                                        (word_cnt_d < num_words_q))) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            // Unfilled lanes of row_buf_q are already zero.
            if (wr_en_q) begin
               state_d = StDone;
            end else if (FlushEn && (lane != '0)) begin
               wr_en_d   = 1'b1;
               wr_data_d = row_buf_q;
               row_buf_d = '0;
            end else begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= StIdle;
         num_words_q <= '0;
         word_cnt_q  <= '0;
         row_buf_q   <= '0;
         wr_data_q   <= '0;
         wr_en_q     <= 1'b0;
         bank_q      <= '0;
         addr_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_words_q <= num_words_d;
         word_cnt_q  <= word_cnt_d;
         row_buf_q   <= row_buf_d;
         wr_data_q   <= wr_data_d;
         wr_en_q     <= wr_en_d;
         bank_q      <= bank_d;
         addr_q      <= addr_d;
         ovf_q       <= ovf_d;
      end
   end

   assign wr_en_o    = wr_en_q;
   assign wr_bank_o  = bank_q;
   assign wr_addr_o  = addr_q;
   assign wr_data_o  = wr_data_q;
   assign busy_o     = (state_q != StIdle);
   assign done_o     = (state_q == StDone);
   assign addr_ovf_o = ovf_q;

endmodule

// File: tb/tb_weight_row_packer.sv
// Scoreboard bench for weight_row_packer: expected writes are queued by stimulus, popped by a monitor.
module tb_weight_row_packer;

   logic          clk;
   logic          rstn;
   logic          start;
   logic [17:0]   num_words;
   logic [31:0]   dma_din;
   logic          dma_din_vld;
   logic          dma_done;
   logic          wr_en;
   logic [3:0]    wr_bank;
   logic [7:0]    wr_addr;
   logic [127:0]  wr_data;
   logic          busy;
   logic          done;
   logic          addr_ovf;

   typedef struct packed {
      logic [3:0]   bank;
      logic [7:0]   addr;
      logic [127:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  last_wr_cyc = -1;
   int  done_cnt = 0;
   int  done_at = -1;

   weight_row_packer #(
      .DIN_W(32), .ROW_W(128), .BANK_NUM(9), .ADDR_W(8), .BITS_TRANS(18)
   ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .start_i      (start),
      .num_words_i  (num_words),
      .dma_din_i    (dma_din),
      .dma_din_vld_i(dma_din_vld),
      .dma_done_i   (dma_done),
      .wr_en_o      (wr_en),
      .wr_bank_o    (wr_bank),
      .wr_addr_o    (wr_addr),
      .wr_data_o    (wr_data),
      .busy_o       (busy),
      .done_o       (done),
      .addr_ovf_o   (addr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every presented write must match the head of the queue.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         last_wr_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got bank %0d addr %0d data %h, expected no write",
                     wr_bank, wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_bank", 128'(wr_bank), 128'(mon_e.bank));
            chk("wr_addr", 128'(wr_addr), 128'(mon_e.addr));
            chk("wr_data", wr_data, mon_e.data);
         end
      end
      if (done === 1'b1) done_cnt++;
   end

   function automatic logic [127:0] row_data(input logic [31:0] base, input int r);
      logic [31:0] w0;
      w0 = base + 32'(4 * r);
      return {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
   endfunction

   task automatic push_row(input int r, input logic [127:0] data);
      wr_t e;
      e.bank = 4'(r % 9);
      e.addr = 8'((r / 9) % 256);
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic push_rows(input logic [31:0] base, input int first, input int last);
      for (int r = first; r <= last; r++) push_row(r, row_data(base, r));
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      num_words = 18'(n);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_words(input int n, input logic [31:0] base, input int start_at);
      for (int i = 0; i < n; i++) begin
         dma_din = base + 32'(i);
         dma_din_vld = 1'b1;
         start = (i == start_at);
         if (i == start_at) num_words = 18'd1;
         @(posedge clk); #1;
      end
      dma_din_vld = 1'b0;
      start = 1'b0;
   endtask

   task automatic pulse_dma_done();
      dma_done = 1'b1;
      @(posedge clk); #1;
      dma_done = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            done_at = cyc;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_done_timeout: got no done, expected done within %0d cycles", name, budget);
      end else begin
         chk({name, "_busy_at_done"}, 128'(busy), 128'd1);
         @(negedge clk);
         chk({name, "_done_single"}, 128'(done), 128'd0);
         chk({name, "_busy_after"}, 128'(busy), 128'd0);
      end
   endtask

   task automatic check_reset_state(input string name);
      chk({name, "_wr_en"}, 128'(wr_en), 128'd0);
      chk({name, "_wr_bank"}, 128'(wr_bank), 128'd0);
      chk({name, "_wr_addr"}, 128'(wr_addr), 128'd0);
      chk({name, "_wr_data"}, wr_data, 128'd0);
      chk({name, "_busy"}, 128'(busy), 128'd0);
      chk({name, "_done"}, 128'(done), 128'd0);
      chk({name, "_addr_ovf"}, 128'(addr_ovf), 128'd0);
   endtask

   initial begin
      int dc;
      rstn = 1'b0;
      start = 1'b0;
      num_words = '0;
      dma_din = '0;
      dma_din_vld = 1'b0;
      dma_done = 1'b0;
      #7;
      check_reset_state("reset");
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // 36 words 1..36 plus one surplus word: 9 rows, banks 0..8 at addr 0.
      push_row(0, 128'h00000004_00000003_00000002_00000001);
      push_rows(32'd1, 1, 8);
      do_start(36);
      chk("A_busy_fill", 128'(busy), 128'd1);
      send_words(37, 32'd1, -1);
      wait_done("A", 6);
      chk("A_done_lag", 128'(done_at - last_wr_cyc), 128'd1);
      chk("A_queue_empty", 128'(exp_q.size()), 128'd0);

      // 40 words with a start pulse mid-job that must be ignored: 10th row at bank 0 addr 1.
      push_rows(32'h100, 0, 8);
      push_row(9, 128'h00000127_00000126_00000125_00000124);
      do_start(40);
      send_words(40, 32'h100, 5);
      wait_done("B", 6);
      chk("B_queue_empty", 128'(exp_q.size()), 128'd0);
      chk("B_no_ovf", 128'(addr_ovf), 128'd0);

      // 6 words then dma_done: partial row flushed only in the macro build.
      push_row(0, 128'h00000004_00000003_00000002_00000001);
`ifdef WEIGHT_PACKER_PARTIAL_FLUSH_EN
      push_row(1, 128'h00000000_00000000_00000006_00000005);
`endif
      do_start(6);
      send_words(6, 32'd1, -1);
      pulse_dma_done();
      wait_done("C", 8);
      chk("C_queue_empty", 128'(exp_q.size()), 128'd0);

      // Empty job.
      dc = done_cnt;
      do_start(0);
      wait_done("D", 2);
      chk("D_one_done", 128'(done_cnt - dc), 128'd1);

      // Asynchronous reset mid-job.
      dc = done_cnt;
      do_start(36);
      send_words(2, 32'd1, -1);
      #2 rstn = 1'b0;
      #1 check_reset_state("midreset");
      @(posedge clk); #1;
      rstn = 1'b1;
      send_words(34, 32'd3, -1);
      repeat (10) @(posedge clk);
      #1;
      chk("E_no_done", 128'(done_cnt - dc), 128'd0);
      chk("E_busy", 128'(busy), 128'd0);

      // Address wrap: 2305 full rows, then 2 words and dma_done.
      push_rows(32'd1, 0, 2304);
`ifdef WEIGHT_PACKER_PARTIAL_FLUSH_EN
      push_row(2305, {64'h0, 32'd9222, 32'd9221});
`endif
      do_start(9232);
      chk("G_ovf_cleared", 128'(addr_ovf), 128'd0);
      send_words(9222, 32'd1, -1);
      pulse_dma_done();
      wait_done("G", 10);
      chk("G_queue_empty", 128'(exp_q.size()), 128'd0);
      chk("G_addr_ovf", 128'(addr_ovf), 128'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no end of test, expected finish within 2 ms");
      $fatal(1, "timeout");
   end

endmodule
